sim_irq_stim_monitor: RTL

- Parametrised, synthesizable stimulus-and-monitor block for SoC simulation benches.
- Generalises the hand-written per-IRQ forcing loops and end-of-test bookkeeping into one block with NUM_IRQ independent channels and LFSR-driven random assertion delays.
- Also provides the cycle, instruction and tohost counters, plus the pass/fail/timeout verdict.
- Sits beside the core in the test top. Observes the commit PC stream and drives the per-channel IRQ lines that the bench forces onto the PLIC/CLINT nets.

---
 rtl/sim_irq_stim_monitor.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sim_irq_stim_monitor.sv
// IRQ stimulus and end-of-test monitor for SoC benches: NUM_IRQ random-delay IRQ channels
// armed from the commit stream, plus cycle/instr/tohost counters and the pass/fail/timeout verdict.

module sim_irq_chan #(
  parameter int unsigned DELAY_BITS = 10,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic hfclk,
  input  logic rst_n,
  input  logic armed,
  input  logic en,
  input  logic stop,
  input  logic stop_at_ack,
  input  logic ack_hit,
  output logic irq
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COUNT, S_ASSERT, S_DONE} state_e;

  localparam int unsigned DW      = DELAY_BITS + 1;
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  state_e          state_q, state_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            irq_q, irq_d;
  logic            fb;

  // Fibonacci taps 16,14,13,11
  assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      S_IDLE: begin
        if (stop)             state_d = S_DONE;
        else if (armed && en) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!en) state_d = S_IDLE;
        else begin
          dly_d   = {1'b0, lfsr_q[DELAY_BITS-1:0]} + DW'(1);
          lfsr_d  = {lfsr_q[14:0], fb};
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (stop)                  state_d = S_DONE;
        else if (!en)              state_d = S_IDLE;
        else if (dly_q == DW'(1))  state_d = S_ASSERT;
        else                       dly_d   = dly_q - DW'(1);
      end
      // Only the ack releases the line so the handler always runs to mret.
      S_ASSERT: begin
        if (ack_hit) state_d = stop_at_ack ? S_DONE : S_LOAD;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    irq_d = (state_d == S_ASSERT);
  end

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      lfsr_q  <= SEED_NZ;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      lfsr_q  <= lfsr_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;
endmodule

module sim_irq_stim_monitor #(
  parameter int unsigned NUM_IRQ     = 3,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned DELAY_BITS  = 10,
  parameter int unsigned STOP_THRESH = 32,
  parameter int unsigned DONE_CNT    = 8,
  parameter int unsigned TIMEOUT_CYC = 10000000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                    hfclk,
  input  logic                    rst_n,
  input  logic                    commit_valid,
  input  logic [PC_W-1:0]         commit_pc,
  input  logic                    disp_valid,
  input  logic                    disp_ready,
  input  logic [31:0]             result_reg,
  input  logic [PC_W-1:0]         cfg_arm_pc,
  input  logic [PC_W-1:0]         cfg_tohost_pc,
  input  logic [NUM_IRQ*PC_W-1:0] cfg_ack_pc,
  input  logic [NUM_IRQ-1:0]      cfg_irq_en,
  output logic [NUM_IRQ-1:0]      irq_o,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             instr_cnt,
  output logic [31:0]             end_cycle,
  output logic [31:0]             tohost_cnt,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout
);
  localparam logic [31:0] STOP_T  = 32'(STOP_THRESH);
  localparam logic [31:0] DONE_T  = 32'(DONE_CNT);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] end_cycle_q, end_cycle_d;
  logic [31:0] tohost_cnt_q, tohost_cnt_d;
  logic        armed_q, armed_d;
  logic        done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;

  logic               arm_hit, tohost_hit, first_pending;
  logic               stop, stop_at_ack, timeout_set, done_set;
  logic [NUM_IRQ-1:0] ack_hit;

  assign arm_hit       = commit_valid && (commit_pc == cfg_arm_pc);
  assign tohost_hit    = commit_valid && (commit_pc == cfg_tohost_pc);
  assign first_pending = (tohost_cnt_q == '0);
  assign stop          = (tohost_cnt_q > STOP_T);
  // An ack coinciding with the threshold-crossing tohost already sees the stop.
  assign stop_at_ack   = (tohost_cnt_d > STOP_T);
  assign timeout_set   = !timeout_q && !done_q && (cycle_cnt_q == TO_LAST);
  assign done_set      = !done_q && !timeout_q && !timeout_set &&
                         (tohost_cnt_q >= DONE_T) && (irq_o == '0);

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q + 32'd1;
    instr_cnt_d  = instr_cnt_q;
    end_cycle_d  = end_cycle_q;
    tohost_cnt_d = tohost_cnt_q;
    armed_d      = armed_q | arm_hit;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q | timeout_set;
    if (tohost_hit && (tohost_cnt_q != '1)) tohost_cnt_d = tohost_cnt_q + 32'd1;
    if (tohost_hit && first_pending)        end_cycle_d  = cycle_cnt_q;
    if (disp_valid && disp_ready && first_pending && !tohost_hit)
      instr_cnt_d = instr_cnt_q + 32'd1;
    if (done_set) begin
      done_d = 1'b1;
      pass_d = (result_reg == 32'd1);
      fail_d = (result_reg != 32'd1);
    end
  end

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      end_cycle_q  <= '0;
      tohost_cnt_q <= '0;
      armed_q      <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      end_cycle_q  <= end_cycle_d;
      tohost_cnt_q <= tohost_cnt_d;
      armed_q      <= armed_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
    end
  end

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
    assign ack_hit[i] = commit_valid && (commit_pc == cfg_ack_pc[i*PC_W +: PC_W]);
    sim_irq_chan #(
      .DELAY_BITS (DELAY_BITS),
      .SEED       (LFSR_SEED ^ 16'(i + 1))
    ) u_chan (
      .hfclk       (hfclk),
      .rst_n       (rst_n),
      .armed       (armed_q),
      .en          (cfg_irq_en[i]),
      .stop        (stop),
      .stop_at_ack (stop_at_ack),
      .ack_hit     (ack_hit[i]),
      .irq         (irq_o[i])
    );
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;
  assign end_cycle  = end_cycle_q;
  assign tohost_cnt = tohost_cnt_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
endmodule
